// File: rtl/filters_pkg.sv
// Shared width defaults and the control FSM state type for the filters MAC slice.
package filters_pkg;

    localparam int FILT_DW    = 16;
    localparam int FILT_CW    = 16;
    localparam int FILT_AW    = 40;
    localparam int FILT_SHIFT = 15;
    localparam int FILT_OW    = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } fsm_state_e;

endpackage

// File: rtl/filters_sat.sv
// Signed narrowing from IW to OW bits, clipping to the OW-bit range and flagging clipping.
module filters_sat #(
    parameter int IW = 25,
    parameter int OW = 16
) (
    input  logic signed [IW-1:0] data_i,
    output logic signed [OW-1:0] data_o,
    output logic                 sat_o
);

    localparam logic signed [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
    localparam logic signed [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

    logic [IW-OW:0] upper_s;
    logic           fits_s;

    assign upper_s = data_i[IW-1:OW-1];
    assign fits_s  = (&upper_s) | ~(|upper_s);

    // The value fits when every bit above the output sign bit copies it.
    always_comb begin
        data_o = data_i[OW-1:0];
        sat_o  = 1'b0;
        if (fits_s) begin
            data_o = data_i[OW-1:0];
            sat_o  = 1'b0;
        end else if (data_i[IW-1]) begin
            data_o = MIN_V;
            sat_o  = 1'b1;
        end else begin
            data_o = MAX_V;
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/filters_mac_acc.sv
// Three-stage multiply-accumulate (product, accumulator, output) with a global stall.
// Build option: define FILTERS_ROUND_EN to round half up before the final shift.
module filters_mac_acc
    import filters_pkg::*;
#(
    parameter int DW    = FILT_DW,
    parameter int CW    = FILT_CW,
    parameter int AW    = FILT_AW,
    parameter int SHIFT = FILT_SHIFT,
    parameter int OW    = FILT_OW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    input  logic signed [CW-1:0] in_coef,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat
);

    localparam int PW = DW + CW;
    localparam int NW = AW - SHIFT;

`ifdef FILTERS_ROUND_EN
    localparam logic signed [AW-1:0] RND_BIAS = {{(AW-1){1'b0}}, 1'b1} << (SHIFT-1);
`else
    localparam logic signed [AW-1:0] RND_BIAS = {AW{1'b0}};
`endif

    fsm_state_e           state_q, state_d;
    logic signed [PW-1:0] prod_q, prod_d;
    logic                 p1_valid_q, p1_valid_d;
    logic                 p1_first_q, p1_first_d;
    logic                 p1_last_q, p1_last_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 p2_valid_q, p2_valid_d;
    logic                 out_valid_q, out_valid_d;
    logic signed [OW-1:0] out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;

    logic                 advance_s;
    logic signed [AW-1:0] prod_ext_s;
    logic signed [AW-1:0] biased_s;
    logic signed [NW-1:0] shifted_s;
    logic signed [OW-1:0] sat_data_s;
    logic                 sat_flag_s;

    assign advance_s  = out_ready | ~out_valid_q;
    assign in_ready   = advance_s;
    assign prod_ext_s = AW'(prod_q);
    assign biased_s   = acc_q + RND_BIAS;
    assign shifted_s  = NW'(biased_s >>> SHIFT);

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sat    = out_sat_q;

    filters_sat #(
        .IW (NW),
        .OW (OW)
    ) u_sat (
        .data_i (shifted_s),
        .data_o (sat_data_s),
        .sat_o  (sat_flag_s)
    );

    // Next-state for all stages and the IDLE/ACCUM control; everything holds on a stall.
    always_comb begin
        state_d     = state_q;
        prod_d      = prod_q;
        p1_valid_d  = p1_valid_q;
        p1_first_d  = p1_first_q;
        p1_last_d   = p1_last_q;
        acc_d       = acc_q;
        p2_valid_d  = p2_valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (advance_s) begin
            p1_valid_d = in_valid;
            prod_d     = PW'(in_data) * PW'(in_coef);
            p1_first_d = in_first;
            p1_last_d  = in_last;

            // A first beat always restarts, dropping any partial sum; strays in IDLE vanish.
            p2_valid_d = 1'b0;
            if (p1_valid_q && p1_first_q) begin
                acc_d      = prod_ext_s;
                p2_valid_d = p1_last_q;
                state_d    = p1_last_q ? IDLE : ACCUM;
            end else if (p1_valid_q && (state_q == ACCUM)) begin
                acc_d      = acc_q + prod_ext_s;
                p2_valid_d = p1_last_q;
                state_d    = p1_last_q ? IDLE : ACCUM;
            end else begin
                state_d    = state_q;
            end

            out_valid_d = p2_valid_q;
            if (p2_valid_q) begin
                out_data_d = sat_data_s;
                out_sat_d  = sat_flag_s;
            end else begin
                out_data_d = out_data_q;
                out_sat_d  = out_sat_q;
            end
        end else begin
            p2_valid_d = p2_valid_q;
        end
    end

    // Pipeline and FSM registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prod_q      <= {PW{1'b0}};
            p1_valid_q  <= 1'b0;
            p1_first_q  <= 1'b0;
            p1_last_q   <= 1'b0;
            acc_q       <= {AW{1'b0}};
            p2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {OW{1'b0}};
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prod_q      <= prod_d;
            p1_valid_q  <= p1_valid_d;
            p1_first_q  <= p1_first_d;
            p1_last_q   <= p1_last_d;
            acc_q       <= acc_d;
            p2_valid_q  <= p2_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: doc/filters_mac_acc.md
FILTERS_MAC_ACC -- requirements
Module: filters_mac_acc

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  DW, 16, signed sample width
  CW, 16, signed coefficient width
  AW, 40, accumulator width (>= DW+CW+log2(max taps))
  SHIFT, 15, output right-shift (coefficient fraction bits)
  OW, 16, output width
REQ-002 Ports SHALL be, as name, direction, width, meaning:
  clk  in  1  clock
  rst_n  in  1  reset
  in_valid  in  1  input beat valid
  in_ready  out  1  input beat accepted when in_valid && in_ready
  in_data  in  DW  signed sample
  in_coef  in  CW  signed coefficient
  in_first  in  1  first tap of a sequence
  in_last  in  1  last tap of a sequence
  out_valid  out  1  result valid
  out_ready  in  1  downstream accepts result
  out_data  out  OW  signed rounded, saturated result
  out_sat  out  1  out_data was clipped
REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be synchronous and active-low.

Function
REQ-004 Pipeline SHALL be: P1 product register (DW+CW signed), P2 accumulator (AW), P3 output register.
REQ-005 Global stall SHALL apply: in_ready = out_ready || !out_valid; P1..P3 advance only when in_ready = 1.
REQ-006 Last beat accepted in cycle t with no stall SHALL give out_valid = 1 in cycle t+3.
REQ-007 Control FSM SHALL have states IDLE and ACCUM; an accepted in_first beat SHALL load the accumulator with its product and enter ACCUM.
REQ-008 In ACCUM, an accepted beat SHALL add its product; an accepted in_last beat SHALL emit the sum and return to IDLE.
REQ-009 A beat with in_first && in_last SHALL produce a single-tap result equal to its product.
REQ-010 A beat accepted in IDLE without in_first SHALL be discarded with no output.
REQ-011 in_first in ACCUM SHALL discard the partial sum and restart.
REQ-012 The accumulator SHALL wrap in two's complement, with no internal saturation.
REQ-013 Final sum SHALL be arithmetically shifted right by SHIFT to AW-SHIFT bits, then saturated to OW bits: above 2^(OW-1)-1 yields 2^(OW-1)-1, below -2^(OW-1) yields -2^(OW-1), out_sat = 1 in either case.
REQ-014 While out_valid && !out_ready, out_data and out_sat SHALL hold stable and no beat SHALL be lost.
REQ-015 Consecutive sequences SHALL be accepted back-to-back at one beat per cycle and emitted in order.

Reset
REQ-016 Reset SHALL give: out_valid = 0, out_data = 0, out_sat = 0, FSM = IDLE, accumulator = 0, P1/P2 valid flags = 0.
REQ-017 Reset mid-sequence SHALL discard the partial sum; no output SHALL result from pre-reset beats.

Configuration
REQ-018 With FILTERS_ROUND_EN defined, 2^(SHIFT-1) SHALL be added before the shift (round half up).
REQ-019 Without FILTERS_ROUND_EN, the shift SHALL truncate toward minus infinity; latency SHALL be identical in both builds.

Structure
REQ-020 Package filters_pkg SHALL hold the FSM state enum typedef and default width constants.
REQ-021 Narrowing SHALL instantiate existing sub-module filters_sat (IW = AW-SHIFT, OW = OW).

Verification
REQ-022 Single beat, first=last=1, data=16384, coef=16384 -> out_data=8192, out_sat=0, out_valid 3 cycles after accept.
REQ-023 Four beats, data=32767, coef=32767 -> out_data=32767, out_sat=1; same with data=-32768 -> out_data=-32768, out_sat=1.
REQ-024 data=3, coef=16384, single beat -> out_data=2 with FILTERS_ROUND_EN, 1 without; data=-3 -> -1 with, -2 without.
REQ-025 out_ready held 0 for 5 cycles with result pending, two sequences queued -> in_ready=0, out_data stable, both results emitted in order.
REQ-026 rst_n=0 for 1 cycle after 2 of 4 taps -> out_valid=0; next sequence (data=16384, coef=16384, single beat) -> 8192 unaffected.
REQ-027 Beat without in_first in IDLE, followed by valid single-tap sequence -> exactly one output, value of the second sequence.
